// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared state type and limits for spi_sched (ABORT state only with SPI_SCHED_TIMEOUT_EN)
`include "config.sv"

package spi_sched_pkg;

    localparam int REQ_N_MAX = 8;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_POLL    = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
`ifdef SPI_SCHED_TIMEOUT_EN
        ,
        ST_ABORT   = 3'd6
`endif
    } state_e;

endpackage

// File: rtl/config.sv
// rtl/config.sv - bus widths, SPI peripheral register map and bit masks
`ifndef SPI_SCHED_CONFIG_SV
`define SPI_SCHED_CONFIG_SV

`define DATA_N          8
`define PERIPH_N        2

`define SPI_CTRL        2'd0
`define SPI_STAT        2'd1
`define SPI_DATA        2'd2

`define SPI_STAT_RXNE_  0
`define SPI_CTRL_EN     8'h01

`endif

// File: rtl/spi_sched_rr_arbiter.sv
// rtl/spi_sched_rr_arbiter.sv - combinational round-robin arbiter, search starts after last_grant
module rr_arbiter #(
    parameter int REQ_N = 2,
    parameter int IDX_W = $clog2(REQ_N)
) (
    input  logic [REQ_N-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [REQ_N-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    int cand;

    // Walk the ring from last_grant+1; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= REQ_N; k++) begin
            cand = (int'(last_grant) + k) % REQ_N;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_sched.sv
// rtl/spi_sched.sv - shares one SPI peripheral among REQ_N requesters; SPI_SCHED_TIMEOUT_EN enables poll timeout/ABORT
module spi_sched
    import spi_sched_pkg::*;
#(
    parameter int REQ_N    = 2,
    parameter int POLL_MAX = 255
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic [`DATA_N-1:0]        cfg_ctrl,
    input  logic [REQ_N-1:0]          req,
    input  logic [REQ_N*`DATA_N-1:0]  tx_data,
    output logic [REQ_N-1:0]          ack,
    output logic [`DATA_N-1:0]        rx_data,
    output logic                      err,
    output logic                      busy,
    output logic                      bus_we,
    output logic                      bus_oe,
    output logic                      periph_sel,
    output logic [`PERIPH_N-1:0]      periph_addr,
    inout  wire  [`DATA_N-1:0]        bus_data
);

    localparam int IDX_W = $clog2(REQ_N);

    if (REQ_N < 2 || REQ_N > REQ_N_MAX || POLL_MAX < 1) begin : g_bad_params
        $error("spi_sched: parameter out of range");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [`DATA_N-1:0] tx_q, tx_d;
    logic [`DATA_N-1:0] rx_q, rx_d;
    logic [`DATA_N-1:0] wdata;
    logic [`DATA_N-1:0] tx_sel;
    logic               we_c, oe_c;
    logic [REQ_N-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(POLL_MAX + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;
`endif

    rr_arbiter #(
        .REQ_N (REQ_N),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (req),
        .last_grant (last_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .valid      (arb_valid)
    );

    // AND-OR mux of the winning requester's TX byte.
    always_comb begin
        tx_sel = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (arb_grant[i]) begin
                tx_sel = tx_sel | tx_data[i*`DATA_N +: `DATA_N];
            end
        end
    end

    // Sequencer next-state and bus/handshake outputs.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        we_c        = 1'b0;
        oe_c        = 1'b0;
        periph_addr = '0;
        wdata       = '0;
        ack         = '0;
        err         = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
        cnt_d       = cnt_q;
        abort_d     = abort_q;
`endif
        case (state_q)
            ST_INIT: begin
                we_c        = 1'b1;
                periph_addr = `SPI_CTRL;
                wdata       = cfg_ctrl;
                state_d     = ST_IDLE;
`ifdef SPI_SCHED_TIMEOUT_EN
                if (abort_q) state_d = ST_DONE;
`endif
            end
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    tx_d    = tx_sel;
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                we_c        = 1'b1;
                periph_addr = `SPI_DATA;
                wdata       = tx_q;
                state_d     = ST_POLL;
            end
            ST_POLL: begin
                oe_c        = 1'b1;
                periph_addr = `SPI_STAT;
                if (bus_data[`SPI_STAT_RXNE_]) begin
                    state_d = ST_RD_DATA;
`ifdef SPI_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(POLL_MAX - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ABORT;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_RD_DATA: begin
                oe_c        = 1'b1;
                periph_addr = `SPI_DATA;
                rx_d        = bus_data;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                ack[grant_q] = 1'b1;
                last_d       = grant_q;
                state_d      = ST_IDLE;
`ifdef SPI_SCHED_TIMEOUT_EN
                err          = abort_q;
                abort_d      = 1'b0;
`endif
            end
`ifdef SPI_SCHED_TIMEOUT_EN
            ST_ABORT: begin
                // Disable the peripheral, then INIT re-enables it before the error ack.
                we_c        = 1'b1;
                periph_addr = `SPI_CTRL;
                wdata       = cfg_ctrl & ~`SPI_CTRL_EN;
                rx_d        = '0;
                abort_d     = 1'b1;
                state_d     = ST_INIT;
            end
`endif
            default: state_d = ST_INIT;
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_INIT;
            grant_q <= '0;
            last_q  <= IDX_W'(REQ_N - 1);
            tx_q    <= '0;
            rx_q    <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
`ifdef SPI_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
`endif
        end
    end

    // Strobes are gated by reset so the bus is released while n_reset is low.
    assign bus_we     = we_c & n_reset;
    assign bus_oe     = oe_c & n_reset;
    assign periph_sel = bus_we | bus_oe;
    assign bus_data   = bus_we ? wdata : {`DATA_N{1'bz}};
    assign busy       = (state_q != ST_IDLE);
    assign rx_data    = rx_q;

endmodule

// File: tb/tb_spi_sched.sv
// tb/tb_spi_sched.sv - directed table-driven bench for spi_sched with a loopback SPI peripheral model
`include "config.sv"

module tb_spi_sched;

    logic                 clk;
    logic                 n_reset;
    logic [`DATA_N-1:0]   cfg_ctrl;
    logic [1:0]           req;
    logic [2*`DATA_N-1:0] tx_data;
    logic [1:0]           ack;
    logic [`DATA_N-1:0]   rx_data;
    logic                 err, busy, bus_we, bus_oe, periph_sel;
    logic [`PERIPH_N-1:0] periph_addr;
    wire  [`DATA_N-1:0]   bus_data;

    int n_checks = 0;
    int n_fail   = 0;

    spi_sched #(.REQ_N(2), .POLL_MAX(16)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .cfg_ctrl    (cfg_ctrl),
        .req         (req),
        .tx_data     (tx_data),
        .ack         (ack),
        .rx_data     (rx_data),
        .err         (err),
        .busy        (busy),
        .bus_we      (bus_we),
        .bus_oe      (bus_oe),
        .periph_sel  (periph_sel),
        .periph_addr (periph_addr),
        .bus_data    (bus_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral model: loopback, RXNE rises 3 cycles after a DATA write unless muted.
    logic [`DATA_N-1:0] m_ctrl, m_data, m_rd;
    logic               m_rxne, m_mute;
    logic [1:0]         m_cnt;

    always_comb begin
        m_rd = '0;
        if (periph_addr == `SPI_STAT) m_rd[`SPI_STAT_RXNE_] = m_rxne;
        else                          m_rd = m_data;
    end
    assign bus_data = bus_oe ? m_rd : {`DATA_N{1'bz}};

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_ctrl <= '0; m_data <= '0; m_rxne <= 1'b0; m_cnt <= '0;
        end else begin
            if (bus_we && periph_addr == `SPI_CTRL) m_ctrl <= bus_data;
            if (bus_we && periph_addr == `SPI_DATA) begin
                m_data <= bus_data; m_cnt <= 2'd3; m_rxne <= 1'b0;
            end else if (m_cnt != 2'd0) begin
                m_cnt <= m_cnt - 2'd1;
                if (m_cnt == 2'd1 && !m_mute) m_rxne <= 1'b1;
            end
            if (bus_oe && periph_addr == `SPI_DATA) m_rxne <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus protocol invariants, every cycle out of reset.
    always @(negedge clk) begin
        if (n_reset) begin
            check("sel_is_we_or_oe", 32'(periph_sel), 32'(bus_we | bus_oe));
            check("we_oe_exclusive", 32'(bus_we & bus_oe), 32'd0);
        end
    end

    task automatic wait_ack(output logic [1:0] a, output logic [7:0] rx, output logic e);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (ack != 2'b00) break;
        end
        check("ack_seen", 32'(ack != 2'b00), 32'd1);
        a = ack; rx = rx_data; e = err;
        @(negedge clk);
        check("ack_one_cycle", 32'(ack), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic check_init(input string tag);
        #1;
        check({tag, "_init_we"},   32'(bus_we), 32'd1);
        check({tag, "_init_addr"}, 32'(periph_addr), 32'(`SPI_CTRL));
        check({tag, "_init_data"}, 32'(bus_data), 32'h81);
    endtask

    typedef struct {
        logic [1:0] req;
        logic [7:0] tx0;
        logic [7:0] tx1;
        logic [1:0] exp_ack;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t       vecs[6];
    logic [1:0] a;
    logic [7:0] rx;
    logic       e;
    int         polls;

    initial begin
        vecs[0] = '{2'b01, 8'hA5, 8'h00, 2'b01, 8'hA5};
        vecs[1] = '{2'b10, 8'h00, 8'h3C, 2'b10, 8'h3C};
        vecs[2] = '{2'b01, 8'h00, 8'h00, 2'b01, 8'h00};
        vecs[3] = '{2'b11, 8'h11, 8'h22, 2'b10, 8'h22};
        vecs[4] = '{2'b11, 8'h5A, 8'hC3, 2'b01, 8'h5A};
        vecs[5] = '{2'b10, 8'h00, 8'hFF, 2'b10, 8'hFF};

        n_reset = 1'b0; cfg_ctrl = 8'h81; req = 2'b00; tx_data = '0; m_mute = 1'b0;

        // Reset state and INIT register write.
        repeat (2) @(negedge clk);
        check("rst_we", 32'(bus_we), 32'd0);
        check("rst_oe", 32'(bus_oe), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rx", 32'(rx_data), 32'd0);
        n_reset = 1'b1;
        check_init("boot");
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_we", 32'(bus_we), 32'd0);
        check("ctrl_written", 32'(m_ctrl), 32'h81);

        // Table of single transfers; round-robin pointer carries across rows.
        for (int i = 0; i < 6; i++) begin
            req = vecs[i].req;
            tx_data = {vecs[i].tx1, vecs[i].tx0};
            wait_ack(a, rx, e);
            req = 2'b00;
            check($sformatf("vec%0d_ack", i), 32'(a), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d_rx", i), 32'(rx), 32'(vecs[i].exp_rx));
            check($sformatf("vec%0d_err", i), 32'(e), 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end

        // Both requesters held from reset: grants alternate 0,1,0,1.
        req = 2'b11; tx_data = {8'h22, 8'h11};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_ack(a, rx, e);
            check($sformatf("alt%0d_ack", i), 32'(a), (i % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("alt%0d_rx", i), 32'(rx), (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        req = 2'b00;
        for (int n = 0; n < 20 && busy; n++) @(negedge clk);
        check("alt_idle", 32'(busy), 32'd0);

        // Request and TX byte withdrawn right after grant: transfer still completes.
        req = 2'b10; tx_data = {8'h77, 8'h00};
        for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
        check("drop_granted", 32'(busy), 32'd1);
        @(negedge clk);
        req = 2'b00; tx_data = '0;
        wait_ack(a, rx, e);
        check("drop_ack", 32'(a), 32'd2);
        check("drop_rx", 32'(rx), 32'h77);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("drop_no_reack", 32'(ack), 32'd0);
        end

        // Reset pulsed during POLL: no ack, bus released, INIT, then the held request is served.
        req = 2'b01; tx_data = {8'h00, 8'h5E};
        for (int n = 0; n < 20 && !(bus_oe && periph_addr == `SPI_STAT); n++) @(negedge clk);
        check("poll_reached", 32'(bus_oe && periph_addr == `SPI_STAT), 32'd1);
        #2 n_reset = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_we", 32'(bus_we), 32'd0);
        check("midrst_oe", 32'(bus_oe), 32'd0);
        check("midrst_rx", 32'(rx_data), 32'd0);
        @(negedge clk);
        check("midrst_ack2", 32'(ack), 32'd0);
        n_reset = 1'b1;
        check_init("midrst");
        wait_ack(a, rx, e);
        req = 2'b00;
        check("midrst_srv_ack", 32'(a), 32'd1);
        check("midrst_srv_rx", 32'(rx), 32'h5E);
        @(negedge clk);

`ifdef SPI_SCHED_TIMEOUT_EN
        // RXNE never set: 16 POLL cycles, CTRL disable, INIT rewrite, error ack.
        m_mute = 1'b1;
        req = 2'b01; tx_data = {8'h00, 8'h99};
        for (int n = 0; n < 20 && !(bus_oe && periph_addr == `SPI_STAT); n++) @(negedge clk);
        polls = 0;
        for (int n = 0; n < 100 && bus_oe && periph_addr == `SPI_STAT; n++) begin
            polls++;
            @(negedge clk);
        end
        req = 2'b00;
        check("to_poll_cycles", 32'(polls), 32'd16);
        check("to_abort_we", 32'(bus_we), 32'd1);
        check("to_abort_addr", 32'(periph_addr), 32'(`SPI_CTRL));
        check("to_abort_data", 32'(bus_data), 32'h80);
        @(negedge clk);
        check("to_init_we", 32'(bus_we), 32'd1);
        check("to_init_data", 32'(bus_data), 32'h81);
        @(negedge clk);
        check("to_ack", 32'(ack), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_rx", 32'(rx_data), 32'd0);
        @(negedge clk);
        check("to_ack_clear", 32'(ack), 32'd0);
        m_mute = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: test did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
